// File: rtl/rv32i_mem_pkg.sv
// Shared constants and types for the rv32i memory responder and its boot loader.
package rv32i_mem_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [15:0] MMIO_ADDR = 16'hFFFC;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } mem_state_e;

endpackage

// File: rtl/rv32i_mem_if.sv
// Core fetch/data bus plus loader byte stream; master drives requests, slave answers.
interface rv32i_mem_if;

  logic [15:0] pc;
  logic [31:0] instr;
  logic [15:0] address;
  logic        WE;
  logic [31:0] writeData;
  logic [31:0] readData;
  logic        ld_valid;
  logic [7:0]  ld_data;
  logic        ld_last;
  logic        ld_ready;

  modport master (
    output pc, address, WE, writeData, ld_valid, ld_data, ld_last,
    input  instr, readData, ld_ready
  );

  modport slave (
    input  pc, address, WE, writeData, ld_valid, ld_data, ld_last,
    output instr, readData, ld_ready
  );

endinterface

// File: rtl/rv32i_mem_loader.sv
// Boot loader: assembles little-endian bytes into imem words and sequences LOAD -> RUN.
import rv32i_mem_pkg::*;

module rv32i_mem_loader #(
  parameter int IMEM_WORDS = 256,
  localparam int IW = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1,
  localparam int PW = IW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld_valid,
  input  logic [7:0]    ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  output logic          imem_we,
  output logic [IW-1:0] imem_idx,
  output logic [31:0]   imem_wdata,
  output logic          run,
  output logic          ld_err
);

  localparam logic [PW-1:0] WPTR_FULL = PW'(IMEM_WORDS);

  mem_state_e    state_d, state_q;
  logic [1:0]    bcnt_d, bcnt_q;
  logic [PW-1:0] wptr_d, wptr_q;
  logic [31:0]   word_d, word_q;
  logic          ld_err_d, ld_err_q;

  always_comb begin
    state_d    = state_q;
    bcnt_d     = bcnt_q;
    wptr_d     = wptr_q;
    word_d     = word_q;
    ld_err_d   = ld_err_q;
    imem_we    = 1'b0;
    // word_q only ever holds the bytes below bcnt_q, so a partial word is zero-padded
    imem_wdata = word_q | ({24'b0, ld_data} << {bcnt_q, 3'b000});
    if (state_q == LOAD && ld_valid) begin
      if (bcnt_q == 2'd3 || ld_last) begin
        bcnt_d = 2'd0;
        word_d = '0;
        if (wptr_q == WPTR_FULL) begin
          ld_err_d = 1'b1;
        end else begin
          imem_we = 1'b1;
          wptr_d  = wptr_q + 1'b1;
        end
        if (ld_last) state_d = RUN;
      end else begin
        bcnt_d = bcnt_q + 2'd1;
        word_d = imem_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= LOAD;
      bcnt_q   <= '0;
      wptr_q   <= '0;
      word_q   <= '0;
      ld_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      bcnt_q   <= bcnt_d;
      wptr_q   <= wptr_d;
      word_q   <= word_d;
      ld_err_q <= ld_err_d;
    end
  end

  assign imem_idx = wptr_q[IW-1:0];
  assign ld_ready = (state_q == LOAD);
  assign run      = (state_q == RUN);
  assign ld_err   = ld_err_q;

endmodule

// File: rtl/rv32i_mem.sv
// Instruction/data memories for the rv32i core, filled by an on-chip boot loader.
// Define RV32I_MEM_MMIO_EN to map a gpio_out register at byte address 0xFFFC.
import rv32i_mem_pkg::*;

module rv32i_mem #(
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_WORDS = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  rv32i_mem_if.slave   bus,
  output logic         core_rst_n,
  output logic         ld_err,
  output logic [31:0]  gpio_out
);

  localparam int IW = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
  localparam int DW = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;
  localparam logic [14:0] IMEM_LIM = 15'(IMEM_WORDS);
  localparam logic [14:0] DMEM_LIM = 15'(DMEM_WORDS);

  logic [31:0]   imem_q [IMEM_WORDS];
  logic [31:0]   dmem_q [DMEM_WORDS];
  logic          imem_we, run, dmem_we, mmio_hit, i_in_range, d_in_range;
  logic [IW-1:0] imem_idx;
  logic [31:0]   imem_wdata;
  logic          unused_lsbs;

  rv32i_mem_loader #(.IMEM_WORDS(IMEM_WORDS)) u_loader (
    .clk        (clk),
    .rst_n      (rst_n),
    .ld_valid   (bus.ld_valid),
    .ld_data    (bus.ld_data),
    .ld_last    (bus.ld_last),
    .ld_ready   (bus.ld_ready),
    .imem_we    (imem_we),
    .imem_idx   (imem_idx),
    .imem_wdata (imem_wdata),
    .run        (run),
    .ld_err     (ld_err)
  );

  assign core_rst_n  = run;
  assign unused_lsbs = ^{bus.pc[1:0], bus.address[1:0]};
  assign i_in_range  = {1'b0, bus.pc[15:2]} < IMEM_LIM;
  assign d_in_range  = {1'b0, bus.address[15:2]} < DMEM_LIM;

`ifdef RV32I_MEM_MMIO_EN
  logic [31:0] gpio_d, gpio_q;

  assign mmio_hit = (bus.address[15:2] == MMIO_ADDR[15:2]);

  always_comb begin
    gpio_d = gpio_q;
    if (run && bus.WE && mmio_hit) gpio_d = bus.writeData;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) gpio_q <= '0;
    else        gpio_q <= gpio_d;
  end

  assign gpio_out = gpio_q;
`else
  assign mmio_hit = 1'b0;
  assign gpio_out = '0;
`endif

  assign dmem_we = run && bus.WE && !mmio_hit && d_in_range;

  // Arrays carry no reset so contents survive a core reset and reload.
  always_ff @(posedge clk) begin
    if (imem_we) imem_q[imem_idx] <= imem_wdata;
    if (dmem_we) dmem_q[bus.address[DW+1:2]] <= bus.writeData;
  end

  always_comb begin
    bus.instr    = NOP_INSTR;
    bus.readData = '0;
    if (run) begin
      if (i_in_range) bus.instr = imem_q[bus.pc[IW+1:2]];
      if (mmio_hit)        bus.readData = gpio_out;
      else if (d_in_range) bus.readData = dmem_q[bus.address[DW+1:2]];
    end
  end

endmodule

// File: doc/rv32i_mem.md
# rv32i_mem

Memory responder for the `rv32i` core: it serves `instr` for every `pc` and `readData` for every `address`, and commits `writeData` when `WE` is asserted. Instruction memory is filled after reset by an on-chip byte-stream boot loader, which holds the core in reset until loading completes. It sits between the core and the top level and replaces the hand-driven `instr`/`readData` stimulus with real memories.

## Interface
Parameters:
- `IMEM_WORDS`, 256: instruction memory depth in 32-bit words; power of two, at most 16384.
- `DMEM_WORDS`, 256: data memory depth in 32-bit words; power of two, at most 16384.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `pc` in 16: byte address of the instruction from the core.
- `instr` out 32: instruction word returned to the core.
- `address` in 16: byte address of the data access from the core.
- `WE` in 1: data write enable from the core.
- `writeData` in 32: data store word from the core.
- `readData` out 32: data load word returned to the core.
- `ld_valid` in 1: a loader byte is present on `ld_data`.
- `ld_data` in 8: loader byte.
- `ld_last` in 1: qualifies the final loader byte.
- `ld_ready` out 1: the loader accepts a byte.
- `core_rst_n` out 1: active-low reset driven to the core.
- `ld_err` out 1: sticky flag, set when loaded words exceed the instruction memory.
- `gpio_out` out 32: MMIO output register (see Configuration).

## Operation
- FSM states: LOAD and RUN. Reset forces LOAD.
- **LOAD**
  - `ld_ready`=1 and `core_rst_n`=0.
  - `instr`=0x00000013 (NOP). `readData`=0. Data writes are ignored.
  - A byte is accepted on `ld_valid`. Bytes are assembled little-endian: the first byte goes to [7:0].
  - A 2-bit byte counter and a word pointer `wptr` track assembly. On the 4th byte, `imem[wptr]` is written and `wptr` increments.
  - A byte accepted with `ld_last` writes the partial word zero-padded in the upper bytes, then the FSM goes to RUN. If `ld_last` arrives with no byte accepted, it has no effect (it is qualified by `ld_valid`).
  - If `wptr` equals `IMEM_WORDS`, word writes are discarded and `ld_err` is set. `ld_err` clears only on reset.
- **RUN**
  - `ld_ready`=0 and `core_rst_n`=1. Loader inputs are ignored.
  - `instr`=`imem[pc[15:2]]`, combinational. It returns NOP when the index is at or above `IMEM_WORDS`. `pc[1:0]` is ignored.
  - `readData`=`dmem[address[15:2]]`, combinational. It returns 0 when the index is out of range.
  - When `WE` is asserted, `dmem` is written at the clock edge. Out-of-range writes are dropped. `address[1:0]` is ignored; writes are full-word only.
- RUN is left only by reset.
- Memory arrays are not reset. A reset mid-operation returns to LOAD with `wptr`=0 and the byte counter at 0. Memory contents persist until overwritten.

## Timing
- Reset values:
  - `ld_ready`=1, `core_rst_n`=0, `ld_err`=0, `gpio_out`=0.
  - `instr`=NOP, `readData`=0.
  - state=LOAD, `wptr`=0, byte counter=0.
- A byte accepted at edge k with `ld_last` set: the word is written at edge k, state=RUN after edge k, and `core_rst_n` rises after edge k. The core's first fetch therefore sees the fully written memory.
- Instruction and data reads have zero-cycle latency (combinational from the address). Writes take effect at the edge where `WE` is sampled.
- A read and a write to the same address in the same cycle: `readData` shows the old value until the edge.

## Configuration
- `RV32I_MEM_MMIO_EN` defined:
  - Word address 0xFFFC is an MMIO register.
  - A write with `WE` updates `gpio_out` at the edge and does not touch `dmem`.
  - A read returns `gpio_out`.
  - This decode takes priority over the normal range check.
- Not defined: `gpio_out` is tied to 0, and address 0xFFFC behaves as ordinary (out-of-range) data memory.

## Structure
- Package `rv32i_mem_pkg` holds:
  - `NOP_INSTR` = 32'h00000013.
  - The state enum {LOAD, RUN}.
  - `MMIO_ADDR` = 16'hFFFC.
- Sub-module `rv32i_mem_loader` contains the byte assembler, the LOAD/RUN FSM, `wptr` and `ld_err`. It outputs an imem write strobe, index and word, plus `run`.
- The top level holds both arrays, the read muxes and the MMIO decode.

## Test plan
- Reset, then check outputs before any byte: `core_rst_n`=0, `instr`=0x00000013, `ld_ready`=1.
- Load bytes 13 04 30 00 | 13 04 34 00 with `ld_last` on the final byte, then drive `pc`=0 and `pc`=4: expect `instr`=0x00300413 and 0x00340413, and `core_rst_n`=1 one edge after the last byte.
- Load 6 bytes AA BB CC DD 11 22 with `ld_last`, then drive `pc`=4: expect `instr`=0x00002211.
- In RUN, write `address`=0x0010 with `writeData`=0xDEADBEEF and `WE`=1, then read 0x0010 and 0x0012: expect 0xDEADBEEF for both; an out-of-range read at 0x8000 returns 0.
- With `IMEM_WORDS`=4, load 5 words: expect `ld_err`=1 and `imem[0..3]` intact. Then assert `rst_n` low mid-RUN: expect state LOAD, `core_rst_n`=0, `ld_err`=0, and `imem` retained.
- With MMIO enabled, write 0xFFFC with 0x0000000F: expect `gpio_out`=0xF and a readback of 0xF. With MMIO disabled, expect `gpio_out` to stay 0.
